poly_grad_engine: RTL and testbench
===================================

POLY_GRAD_ENGINE -- requirements
Module: poly_grad_engine

Interface
REQ-001 Parameter W, default 32: data width of x and coefficients, signed fixed point.
REQ-002 Parameter F, default 8: fractional bits, so the default format is Q24.8.
REQ-003 Parameter DEG, default 4: polynomial degree, with DEG+1 coefficients; the legal range is 1..15.
REQ-004 Parameter ACC_W, default 2*W: width of value and gradient, Q(ACC_W-F).F.
REQ-005 The module SHALL have these ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: request to start a run.
- x_in, input, W: initial x.
- coef_we, input, 1: coefficient write enable.
- coef_addr, input, $clog2(DEG+1): coefficient index k, for the term c_k·x^k.
- coef_wdata, input, W: coefficient in Q format.
- step_shift, input, 5: learning rate, 2^-step_shift.
- iter_count, input, 8: maximum descent iterations; 0 is treated as 1.
- busy, output, 1: run in progress.
- done, output, 1: one-cycle completion pulse.
- value, output, ACC_W: p(x) at the last evaluated x.
- gradient, output, ACC_W: p'(x) at the last evaluated x.
- x_diff_out, output, W: last step applied to x.
- x_next, output, W: x after the last step.
- overflow, output, 1: sticky saturation flag for the current run.

Function
REQ-006 The FSM SHALL have states IDLE, LOAD, HORNER, UPDATE and DONE.
REQ-007 In IDLE, start=1 SHALL do the following:
- latch x_in, step_shift and iter_count;
- clear overflow and the iteration counter;
- go to LOAD.
REQ-008 LOAD SHALL initialise v=c_DEG and d=0, then go to HORNER.
REQ-009 HORNER SHALL run DEG cycles, k=DEG-1 down to 0, updating both accumulators in the same cycle from the old v:
- d := sat(d·x>>>F + v);
- v := sat(v·x>>>F + c_k).
REQ-010 All products SHALL be full-precision signed, followed by an arithmetic right shift of F, then saturated to ACC_W; any saturation SHALL set overflow.
REQ-011 UPDATE SHALL register value=v and gradient=d, then compute:
- x_diff = sat_W(-(d>>>step_shift));
- x_next = sat_W(x + x_diff).
Any W-saturation SHALL set overflow.
REQ-012 After UPDATE, the FSM SHALL go to DONE if the iteration count is reached or x_diff==0; otherwise it SHALL set x:=x_next and return to LOAD.
REQ-013 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-014 done SHALL rise DEG+3 rising edges after the edge that samples start; each extra iteration SHALL add DEG+2 cycles.
REQ-015 busy SHALL be 1 in the states LOAD, HORNER, UPDATE and DONE.
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 The value, gradient, x_diff_out, x_next and overflow outputs SHALL hold their values from done until the next accepted start.
REQ-018 coef_we SHALL write coefficient register coef_addr when busy=0; writes while busy=1 SHALL be dropped.
REQ-019 coef_we with coef_addr>DEG SHALL be ignored.
REQ-020 If start and coef_we are both asserted in IDLE in the same cycle, the write SHALL take effect first, so the run uses the new coefficient.
REQ-021 Negative values of x, coefficients and gradient SHALL be handled in two's complement, with the shift rounding toward -inf.

Reset
REQ-022 rst=1 SHALL asynchronously force the FSM to IDLE and clear all coefficient registers to 0.
REQ-023 rst=1 SHALL asynchronously clear busy, done, value, gradient, x_diff_out, x_next and overflow to 0.
REQ-024 Reset asserted mid-run SHALL abort the run with no done pulse; a start after reset release SHALL be accepted normally.

Structure
REQ-025 Package poly_grad_pkg SHALL hold:
- the FSM state enum;
- default W, F, DEG and ACC_W;
- signed saturate functions to ACC_W and to W.
REQ-026 One sub-module, poly_horner_mac, SHALL implement a single saturating step sat(a·x>>>F + b) with an overflow output; it SHALL be instantiated twice, once for v and once for d.

Verification
REQ-027 Single evaluation, coefficient values in hex (c2=0x100, c1=0xFFFFFC00, others 0), x_in=0x100, step_shift=1, iter_count=1:
- value=-3.0, gradient=-2.0, x_diff_out=+1.0, x_next=2.0;
- done rises at cycle DEG+3.
REQ-028 Same coefficients, x_in=0x100, iter_count=8:
- early stop after 2 iterations;
- x_next=0x200, gradient=0, value=-4.0, x_diff_out=0.
REQ-029 Overflow, c4=0x100, x_in=0x7FFFFF00, iter_count=1:
- value=max positive ACC_W;
- overflow=1;
- no hang, done pulses.
REQ-030 Negative path, c2=0x100, x_in=0xFFFFFD00 (-3.0), step_shift=2:
- gradient=-6.0;
- x_diff_out=+1.5, computed as -(-6.0>>>2);
- x_next=-1.5.
REQ-031 Protocol checks:
- start pulsed while busy causes no restart;
- coef_we while busy leaves the coefficient unchanged;
- rst asserted in HORNER gives all outputs 0 with no done, and the next run is correct.

Source files
------------

// File: rtl/poly_grad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : poly_grad_pkg
//  Purpose  : Shared state encoding, default widths and saturation helpers
//             for the polynomial gradient-descent engine.
//  Revision : 1.0 - initial release
// ============================================================================
package poly_grad_pkg;

    localparam int DEF_W     = 32;
    localparam int DEF_F     = 8;
    localparam int DEF_DEG   = 4;
    localparam int DEF_ACC_W = 2 * DEF_W;

    // Working width for intermediate sums; wide enough for ACC_W+W+1 at
    // every legal parameterisation the engine is used with.
    localparam int SAT_W = 128;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        HORNER = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] v,
        input int                      w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -hi - 128'sd1;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

    // Saturate to the accumulator width.
    function automatic logic signed [SAT_W-1:0] sat_acc(
        input logic signed [SAT_W-1:0] v,
        input int                      acc_w
    );
        return sat_signed(v, acc_w);
    endfunction

    // Saturate to the data (x / coefficient) width.
    function automatic logic signed [SAT_W-1:0] sat_w(
        input logic signed [SAT_W-1:0] v,
        input int                      w
    );
        return sat_signed(v, w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/poly_horner_mac.sv
`default_nettype none
// ============================================================================
//  Module   : poly_horner_mac
//  Purpose  : One saturating Horner step y = sat(a*x >>> F + b), with a flag
//             raised whenever the result had to be clamped.
//  Revision : 1.0 - initial release
// ============================================================================
module poly_horner_mac
    import poly_grad_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int F     = DEF_F,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [W-1:0]     x,
    input  logic signed [ACC_W-1:0] b,
    output logic signed [ACC_W-1:0] y,
    output logic                    ovf
);

    localparam int PW = ACC_W + W;

    logic signed [PW-1:0]    prod;
    logic signed [PW:0]      sum;
    logic signed [SAT_W-1:0] wide;
    logic signed [SAT_W-1:0] clipped;

    // Full-precision product, floor-shift by F, add, then clamp to ACC_W.
    always_comb begin
        prod    = a * x;
        sum     = (PW+1)'(prod >>> F) + (PW+1)'(b);
        wide    = SAT_W'(sum);
        clipped = sat_acc(wide, ACC_W);
        y       = clipped[ACC_W-1:0];
        ovf     = (clipped != wide);
    end

endmodule
`default_nettype wire

// File: rtl/poly_grad_engine.sv
`default_nettype none
// ============================================================================
//  Module   : poly_grad_engine
//  Purpose  : Evaluates p(x) and p'(x) by a joint Horner recurrence and walks
//             x downhill with a power-of-two learning rate until the
//             iteration budget is spent or the step becomes zero.
//  Revision : 1.0 - initial release
// ============================================================================
module poly_grad_engine
    import poly_grad_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int F     = DEF_F,
    parameter int DEG   = DEF_DEG,
    parameter int ACC_W = 2 * W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [W-1:0]               x_in,
    input  logic                       coef_we,
    input  logic [$clog2(DEG+1)-1:0]   coef_addr,
    input  logic [W-1:0]               coef_wdata,
    input  logic [4:0]                 step_shift,
    input  logic [7:0]                 iter_count,
    output logic                       busy,
    output logic                       done,
    output logic [ACC_W-1:0]           value,
    output logic [ACC_W-1:0]           gradient,
    output logic [W-1:0]               x_diff_out,
    output logic [W-1:0]               x_next,
    output logic                       overflow
);

    localparam int AW = $clog2(DEG + 1);

    state_t state, state_nxt;

    logic signed [W-1:0]     coef [0:DEG];
    logic signed [W-1:0]     x_r;
    logic [4:0]              shift_r;
    logic [7:0]              iter_max;
    logic [7:0]              iter_cnt;
    logic [AW-1:0]           k;
    logic signed [ACC_W-1:0] v;
    logic signed [ACC_W-1:0] d;

    logic signed [ACC_W-1:0] c_k_ext;
    logic signed [ACC_W-1:0] v_new;
    logic signed [ACC_W-1:0] d_new;
    logic                    ovf_v;
    logic                    ovf_d;

    logic signed [SAT_W-1:0] diff_wide;
    logic signed [SAT_W-1:0] diff_sat;
    logic signed [SAT_W-1:0] sum_wide;
    logic signed [SAT_W-1:0] nxt_sat;
    logic signed [W-1:0]     step_diff;
    logic signed [W-1:0]     step_next;
    logic                    step_ovf;
    logic [7:0]              iter_eff;
    logic                    stop;

    assign c_k_ext = ACC_W'(coef[k]);

    // v-chain: v := sat(v*x >>> F + c_k)
    poly_horner_mac #(.W(W), .F(F), .ACC_W(ACC_W)) u_mac_v (
        .a   (v),
        .x   (x_r),
        .b   (c_k_ext),
        .y   (v_new),
        .ovf (ovf_v)
    );

    // d-chain uses the pre-update v: d := sat(d*x >>> F + v)
    poly_horner_mac #(.W(W), .F(F), .ACC_W(ACC_W)) u_mac_d (
        .a   (d),
        .x   (x_r),
        .b   (v),
        .y   (d_new),
        .ovf (ovf_d)
    );

    // Descent step and termination decision computed from the finished d.
    always_comb begin
        diff_wide = -(SAT_W'(d) >>> shift_r);
        diff_sat  = sat_w(diff_wide, W);
        step_diff = diff_sat[W-1:0];
        sum_wide  = SAT_W'(x_r) + SAT_W'(step_diff);
        nxt_sat   = sat_w(sum_wide, W);
        step_next = nxt_sat[W-1:0];
        step_ovf  = (diff_sat != diff_wide) || (nxt_sat != sum_wide);
        iter_eff  = (iter_max == 8'd0) ? 8'd1 : iter_max;
        stop      = (({1'b0, iter_cnt} + 9'd1) >= {1'b0, iter_eff}) ||
                    (step_diff == '0);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and busy decode.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = LOAD;
            end
            LOAD:    state_nxt = HORNER;
            HORNER:  if (k == '0) state_nxt = UPDATE;
            UPDATE:  state_nxt = stop ? DONE : LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Coefficient file: writable only while idle and only for valid indices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= DEG; i++) coef[i] <= '0;
        end else if (coef_we && (state == IDLE) && (int'(coef_addr) <= DEG)) begin
            coef[coef_addr] <= coef_wdata;
        end
    end

    // Datapath registers, result outputs and the completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r        <= '0;
            shift_r    <= '0;
            iter_max   <= '0;
            iter_cnt   <= '0;
            k          <= '0;
            v          <= '0;
            d          <= '0;
            value      <= '0;
            gradient   <= '0;
            x_diff_out <= '0;
            x_next     <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        x_r      <= x_in;
                        shift_r  <= step_shift;
                        iter_max <= iter_count;
                        iter_cnt <= '0;
                        overflow <= 1'b0;
                    end
                end
                LOAD: begin
                    v <= ACC_W'(coef[DEG]);
                    d <= '0;
                    k <= AW'(DEG - 1);
                end
                HORNER: begin
                    v        <= v_new;
                    d        <= d_new;
                    overflow <= overflow | ovf_v | ovf_d;
                    if (k != '0) k <= k - 1'b1;
                end
                UPDATE: begin
                    value      <= v;
                    gradient   <= d;
                    x_diff_out <= step_diff;
                    x_next     <= step_next;
                    overflow   <= overflow | step_ovf;
                    iter_cnt   <= iter_cnt + 8'd1;
                    if (!stop) x_r <= step_next;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_poly_grad_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_poly_grad_engine
//  Purpose  : Directed self-checking bench for poly_grad_engine (defaults:
//             W=32, F=8, DEG=4, ACC_W=64).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_poly_grad_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] x_in;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [31:0] coef_wdata;
    logic [4:0]  step_shift;
    logic [7:0]  iter_count;
    logic        busy;
    logic        done;
    logic [63:0] value;
    logic [63:0] gradient;
    logic [31:0] x_diff_out;
    logic [31:0] x_next;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int cyc;

    poly_grad_engine dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .x_in       (x_in),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .step_shift (step_shift),
        .iter_count (iter_count),
        .busy       (busy),
        .done       (done),
        .value      (value),
        .gradient   (gradient),
        .x_diff_out (x_diff_out),
        .x_next     (x_next),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr_coef(input logic [2:0] a, input logic [31:0] dta);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = a;
        coef_wdata = dta;
        @(negedge clk);
        coef_we    = 1'b0;
    endtask

    // Start a run; cycles counts rising edges after the start-sampling edge
    // up to the one after which done is seen high.
    task automatic run(input logic [31:0] xi, input logic [4:0] sh, input logic [7:0] it,
                       input bit poke, input bit wr, input logic [2:0] wa,
                       input logic [31:0] wd, output int cycles);
        @(negedge clk);
        x_in       = xi;
        step_shift = sh;
        iter_count = it;
        start      = 1'b1;
        if (wr) begin
            coef_we    = 1'b1;
            coef_addr  = wa;
            coef_wdata = wd;
        end
        @(posedge clk); #1;
        start   = 1'b0;
        coef_we = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        cycles = 0;
        while (!done && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
            if (poke && cycles == 2) begin
                start      = 1'b1;
                coef_we    = 1'b1;
                coef_addr  = 3'd2;
                coef_wdata = 32'h0000_0500;
            end else if (poke && cycles == 3) begin
                start   = 1'b0;
                coef_we = 1'b0;
            end
        end
        check("done_seen", {63'd0, done}, 64'd1);
        @(posedge clk); #1;
        check("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic saw_done;
        rst = 1'b1; start = 1'b0; x_in = '0; coef_we = 1'b0; coef_addr = '0;
        coef_wdata = '0; step_shift = '0; iter_count = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_value",    value, 64'd0);
        check("rst_busy",     {63'd0, busy}, 64'd0);
        check("rst_done",     {63'd0, done}, 64'd0);
        check("rst_x_next",   {32'd0, x_next}, 64'd0);
        @(negedge clk); rst = 1'b0;

        // p(x) = x^2 - 4x
        wr_coef(3'd2, 32'h0000_0100);
        wr_coef(3'd1, 32'hFFFF_FC00);

        // Single evaluation at x = 1.0
        run(32'h0000_0100, 5'd1, 8'd1, 1'b0, 1'b0, 3'd0, 32'd0, cyc);
        check("single_latency", 64'(cyc), 64'd7);
        check("single_value",   value, 64'hFFFF_FFFF_FFFF_FD00);
        check("single_grad",    gradient, 64'hFFFF_FFFF_FFFF_FE00);
        check("single_xdiff",   {32'd0, x_diff_out}, 64'h0000_0100);
        check("single_xnext",   {32'd0, x_next}, 64'h0000_0200);
        check("single_ovf",     {63'd0, overflow}, 64'd0);
        check("hold_busy",      {63'd0, busy}, 64'd0);

        // Descent with early stop at the minimum x = 2.0
        run(32'h0000_0100, 5'd1, 8'd8, 1'b0, 1'b0, 3'd0, 32'd0, cyc);
        check("multi_latency", 64'(cyc), 64'd13);
        check("multi_xnext",   {32'd0, x_next}, 64'h0000_0200);
        check("multi_grad",    gradient, 64'd0);
        check("multi_value",   value, 64'hFFFF_FFFF_FFFF_FC00);
        check("multi_xdiff",   {32'd0, x_diff_out}, 64'd0);

        // iter_count = 0 behaves as a single iteration
        run(32'h0000_0100, 5'd1, 8'd0, 1'b0, 1'b0, 3'd0, 32'd0, cyc);
        check("iter0_latency", 64'(cyc), 64'd7);
        check("iter0_xnext",   {32'd0, x_next}, 64'h0000_0200);

        // start and coef_we while busy are both ignored
        run(32'h0000_0100, 5'd1, 8'd1, 1'b1, 1'b0, 3'd0, 32'd0, cyc);
        check("poke_latency", 64'(cyc), 64'd7);
        check("poke_value",   value, 64'hFFFF_FFFF_FFFF_FD00);
        run(32'h0000_0100, 5'd1, 8'd1, 1'b0, 1'b0, 3'd0, 32'd0, cyc);
        check("coef_kept_value", value, 64'hFFFF_FFFF_FFFF_FD00);
        check("coef_kept_grad",  gradient, 64'hFFFF_FFFF_FFFF_FE00);

        // p(x) = x^2 at x = -3.0, step 2^-2
        wr_coef(3'd1, 32'd0);
        run(32'hFFFF_FD00, 5'd2, 8'd1, 1'b0, 1'b0, 3'd0, 32'd0, cyc);
        check("neg_value", value, 64'h0000_0000_0000_0900);
        check("neg_grad",  gradient, 64'hFFFF_FFFF_FFFF_FA00);
        check("neg_xdiff", {32'd0, x_diff_out}, 64'h0000_0180);
        check("neg_xnext", {32'd0, x_next}, 64'hFFFF_FE80);

        // Floor rounding of the shift: -1536 >>> 10 = -2
        run(32'hFFFF_FD00, 5'd10, 8'd1, 1'b0, 1'b0, 3'd0, 32'd0, cyc);
        check("floor_xdiff", {32'd0, x_diff_out}, 64'h0000_0002);
        check("floor_xnext", {32'd0, x_next}, 64'hFFFF_FD02);

        // p(x) = x^4 near the top of the Q24.8 range saturates
        wr_coef(3'd2, 32'd0);
        wr_coef(3'd4, 32'h0000_0100);
        run(32'h7FFF_FF00, 5'd1, 8'd1, 1'b0, 1'b0, 3'd0, 32'd0, cyc);
        check("ovf_latency", 64'(cyc), 64'd7);
        check("ovf_value",   value, 64'h7FFF_FFFF_FFFF_FFFF);
        check("ovf_flag",    {63'd0, overflow}, 64'd1);
        check("ovf_xdiff",   {32'd0, x_diff_out}, 64'h8000_0000);
        check("ovf_xnext",   {32'd0, x_next}, 64'hFFFF_FF00);

        // overflow is cleared by the next accepted start
        wr_coef(3'd4, 32'd0);
        wr_coef(3'd2, 32'h0000_0100);
        run(32'hFFFF_FD00, 5'd2, 8'd1, 1'b0, 1'b0, 3'd0, 32'd0, cyc);
        check("ovf_cleared", {63'd0, overflow}, 64'd0);
        check("ovf_cl_value", value, 64'h0000_0000_0000_0900);

        // Reset asserted while in HORNER aborts with everything cleared
        @(negedge clk);
        x_in = 32'h0000_0100; step_shift = 5'd1; iter_count = 8'd1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b1;
        #1;
        check("mid_rst_value", value, 64'd0);
        check("mid_rst_grad",  gradient, 64'd0);
        check("mid_rst_xnext", {32'd0, x_next}, 64'd0);
        check("mid_rst_xdiff", {32'd0, x_diff_out}, 64'd0);
        check("mid_rst_busy",  {63'd0, busy}, 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        check("mid_rst_no_done", {63'd0, saw_done}, 64'd0);
        @(negedge clk); rst = 1'b0;

        // Coefficients were cleared; the c1 write shares the start cycle
        wr_coef(3'd2, 32'h0000_0100);
        run(32'h0000_0100, 5'd1, 8'd1, 1'b0, 1'b1, 3'd1, 32'hFFFF_FC00, cyc);
        check("post_rst_latency", 64'(cyc), 64'd7);
        check("post_rst_value",   value, 64'hFFFF_FFFF_FFFF_FD00);
        check("post_rst_grad",    gradient, 64'hFFFF_FFFF_FFFF_FE00);
        check("post_rst_xnext",   {32'd0, x_next}, 64'h0000_0200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
